// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RSP = 2'd1,
    DROP     = 2'd2
  } fetch_state_e;

  // Bit positions and widths of the decoded instruction fields.
  localparam int OPC_LSB = 0;
  localparam int OPC_W   = 7;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int F3_W    = 3;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int REG_W   = 5;
  localparam int F7_LSB  = 25;
  localparam int F7_W    = 7;
  localparam int IMM_LSB = 7;
  localparam int IMM_W   = 25;

  // One queue entry for a 32-bit core: fetched word and the address it came from.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with power-of-two depth and a single-cycle flush.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_LEVEL);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot a full queue would otherwise lack.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];
  assign count   = cnt;

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage write; entries carry no reset, occupancy decides validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetcher: one outstanding memory request, buffered into a small queue.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [6:0]      opcode_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic [24:0]     imm_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_L = (AW+2)'(DEPTH);

  fetch_state_e      state;
  fetch_state_e      state_next;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   req_pc;
  logic              req;
  logic              grant;
  logic              push;
  logic              pop;
  logic              empty;
  logic [AW:0]       count;
  logic [AW+1:0]     level_next;
  logic [2*XLEN-1:0] head;

  // Redirect squashes both the head handshake and any arriving response.
  assign pop        = instr_valid_o & instr_ready_i & ~redirect_i;
  assign push       = (state == WAIT_RSP) & imem_rvalid_i & ~redirect_i;
  assign level_next = {1'b0, count} + {{(AW+1){1'b0}}, push} - {{(AW+1){1'b0}}, pop};
  assign grant      = req & imem_gnt_i;

  // Next-state and request generation; a request needs room after this cycle's push/pop.
  always_comb begin
    state_next = state;
    req        = 1'b0;
    unique case (state)
      IDLE: begin
        req = ~redirect_i & (level_next < DEPTH_L);
        if (req && imem_gnt_i) state_next = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (imem_rvalid_i) begin
          state_next = IDLE;
          req        = ~redirect_i & (level_next < DEPTH_L);
          if (req && imem_gnt_i) state_next = WAIT_RSP;
        end else if (redirect_i) begin
          state_next = DROP;
        end
      end
      DROP: begin
        // The orphaned response always arrives; only then is it safe to fetch again.
        if (imem_rvalid_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (rst_i) req = 1'b0;
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Fetch PC: restart on reset or redirect, otherwise step past each granted word.
  always_ff @(posedge clk_i) begin
    if (rst_i)           pc <= RESET_PC;
    else if (redirect_i) pc <= redirect_pc_i & ~XLEN'(3);
    else if (grant)      pc <= pc + XLEN'(4);
  end

  // Remember the address of the request in flight so the response can be tagged.
  always_ff @(posedge clk_i) begin
    if (grant) req_pc <= pc;
  end

  sync_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (redirect_i),
    .push  (push),
    .wdata ({imem_rdata_i, req_pc}),
    .pop   (pop),
    .rdata (head),
    .empty (empty),
    .count (count)
  );

  assign imem_req_o    = req;
  assign imem_addr_o   = pc;
  assign instr_valid_o = ~empty;
  assign instr_o       = head[2*XLEN-1:XLEN];
  assign pc_o          = head[XLEN-1:0];

  assign rs1_o    = instr_o[RS1_LSB +: REG_W];
  assign rs2_o    = instr_o[RS2_LSB +: REG_W];
  assign rd_o     = instr_o[RD_LSB  +: REG_W];
  assign opcode_o = instr_o[OPC_LSB +: OPC_W];
  assign funct3_o = instr_o[F3_LSB  +: F3_W];
  assign funct7_o = instr_o[F7_LSB  +: F7_W];
  assign imm_o    = instr_o[IMM_LSB +: IMM_W];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue with a transaction-level reference model.
module tb_instr_fetch_queue;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [24:0] imm;

  instr_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .pc_o          (pc),
    .rs1_o         (rs1),
    .rs2_o         (rs2),
    .rd_o          (rd),
    .opcode_o      (opcode),
    .funct3_o      (funct3),
    .funct7_o      (funct7),
    .imm_o         (imm)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory contents: one known R-type word at 0x40, a hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h00C58533;
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // Reference model: expected queue of fetch addresses, next fetch address, memory state.
  logic [31:0] q[$];
  logic [31:0] exp_fetch = RESET_PC;
  bit          mem_busy = 0;
  bit          stale_rst = 0;
  bit          stale_redir = 0;
  logic [31:0] mem_addr = '0;
  int          mem_delay = 0;

  int p_gnt = 100, p_ready = 100, p_redir = 0, p_rst = 0, max_dly = 0;
  bit want37 = 0, want38 = 0, want39 = 0;
  bit          watch_en = 0;
  logic [31:0] watch_exp = '0;
  string       watch_tag = "";

  task automatic cycle();
    logic [31:0] e;
    int pop, push, lvl;
    bit wait_st, req_exp;
    @(posedge clk);
    #1;
    rst         = ($urandom_range(0, 99) < p_rst);
    redirect    = ($urandom_range(0, 99) < p_redir);
    redirect_pc = $urandom_range(0, 1023);
    instr_ready = ($urandom_range(0, 99) < p_ready);
    imem_rvalid = mem_busy && (mem_delay == 0);
    imem_gnt    = (!mem_busy || imem_rvalid) && ($urandom_range(0, 99) < p_gnt);
    imem_rdata  = imem_rvalid ? mem_word(mem_addr) : $urandom;
    if (want37 && mem_busy && !imem_rvalid && !stale_rst && !stale_redir && !rst) begin
      redirect = 1; redirect_pc = 32'h100; want37 = 0;
      watch_en = 1; watch_exp = 32'h100; watch_tag = "redir_wait_addr";
    end
    if (want38 && imem_rvalid && !stale_rst && !stale_redir && q.size() > 0 && !rst) begin
      redirect = 1; redirect_pc = 32'h203; instr_ready = 1; want38 = 0;
      watch_en = 1; watch_exp = 32'h200; watch_tag = "redir_pushpop_addr";
    end
    if (want39 && mem_busy && !imem_rvalid && !stale_rst && !stale_redir) begin
      rst = 1; redirect = 1; redirect_pc = 32'h300; want39 = 0;
      watch_en = 1; watch_exp = RESET_PC; watch_tag = "rst_redir_addr";
    end
    #1;
    pop  = (instr_valid && instr_ready && !redirect && !rst) ? 1 : 0;
    push = (imem_rvalid && !stale_rst && !stale_redir && !redirect && !rst) ? 1 : 0;
    chk("instr_valid", instr_valid, q.size() > 0);
    if (q.size() > 0) begin
      e = mem_word(q[0]);
      chk("pc_o", pc, q[0]);
      chk("instr_o", instr, e);
      chk("rs1", rs1, e[19:15]);
      chk("rs2", rs2, e[24:20]);
      chk("rd", rd, e[11:7]);
      chk("opcode", opcode, e[6:0]);
      chk("funct3", funct3, e[14:12]);
      chk("funct7", funct7, e[31:25]);
      chk("imm", imm, e[31:7]);
      if (q[0] == 32'h40) begin
        chk("dec_rs1", rs1, 11);
        chk("dec_rs2", rs2, 12);
        chk("dec_rd", rd, 10);
        chk("dec_opcode", opcode, 7'h33);
        chk("dec_funct3", funct3, 0);
        chk("dec_funct7", funct7, 0);
      end
    end
    lvl     = q.size() + push - pop;
    wait_st = mem_busy && !stale_rst;
    req_exp = !rst && !redirect && (lvl < DEPTH) && (!wait_st || (imem_rvalid && !stale_redir));
    chk("imem_req", imem_req, req_exp);
    if (req_exp) chk("imem_addr", imem_addr, exp_fetch);
    if (watch_en && req_exp) begin
      chk(watch_tag, imem_addr, watch_exp);
      watch_en = 0;
    end
    // Apply what happens at the coming edge.
    if (rst) begin
      q.delete();
      exp_fetch = RESET_PC;
    end else if (redirect) begin
      q.delete();
      exp_fetch = redirect_pc & ~32'h3;
    end else begin
      if (pop != 0)  void'(q.pop_front());
      if (push != 0) q.push_back(mem_addr);
    end
    if (imem_rvalid) begin
      mem_busy = 0; stale_rst = 0; stale_redir = 0;
    end else if (mem_busy) begin
      mem_delay--;
      if (rst) stale_rst = 1;
      else if (redirect) stale_redir = 1;
    end
    if (imem_req && imem_gnt && !rst) begin
      mem_busy  = 1;
      mem_addr  = exp_fetch;
      mem_delay = $urandom_range(0, max_dly);
      exp_fetch = exp_fetch + 32'd4;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    // Reset cycle itself: nothing requested, nothing valid afterwards.
    p_rst = 100; run(2); p_rst = 0;
    // Streaming fetch with an always-ready consumer and single-cycle memory.
    p_gnt = 100; p_ready = 100; max_dly = 0; run(30);
    // Stall the consumer from a clean start: queue fills, then fetch resumes at 0x10.
    p_rst = 100; run(2); p_rst = 0;
    p_ready = 0; run(15);
    p_ready = 100; watch_en = 1; watch_exp = 32'h10; watch_tag = "resume_addr"; run(10);
    // Redirect while a request is outstanding.
    want37 = 1; p_gnt = 70; p_ready = 60; max_dly = 2; run(20);
    // Redirect coinciding with push and pop.
    want38 = 1; p_gnt = 100; p_ready = 100; max_dly = 0; run(20);
    // Reset together with redirect while waiting for a response.
    want39 = 1; p_gnt = 80; p_ready = 50; max_dly = 3; run(20);
    chk("directed_cases_done", {want37, want38, want39, watch_en}, 4'b0000);
    // Long random run.
    p_gnt = 60; p_ready = 60; p_redir = 5; p_rst = 1; max_dly = 3; watch_en = 0; run(2000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
